seq_div8x4: RTL
===============

// Module: seq_div8x4
// PURPOSE
//  Sequential restoring binary divider: 8-bit dividend / 4-bit divisor -> 8-bit quotient, 4-bit remainder.
//  Inverse partner of the 4x4 array multiplier; products it forms are recovered here (p / b -> a, rem 0).
//  Start/done handshake, one quotient bit per clock; sits beside the multiplier in the arithmetic datapath.
// PARAMETERS
//  N  8  dividend/quotient width
//  D  4  divisor/remainder width (N >= D)
// PORTS
//  clk          in   1  rising-edge clock, single clock domain
//  rst_n        in   1  reset, asynchronous, active-low
//  start        in   1  request; sampled only when busy=0
//  dividend     in   N  unsigned dividend, sampled with start
//  divisor      in   D  unsigned divisor, sampled with start
//  busy         out  1  division in progress
//  done         out  1  one-cycle pulse: results valid
//  quotient     out  N  unsigned quotient, held until next accepted start
//  remainder    out  D  unsigned remainder, held until next accepted start
//  div_by_zero  out  1  set with done when divisor was 0; held with results
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internals cleared.
//  States: IDLE, RUN. Internal: q_sh[N], r_acc[D+1], dvs[D], cnt[$clog2(N+1)].
//  IDLE, start=1 at edge k, divisor!=0: q_sh<=dividend, r_acc<=0, dvs<=divisor, cnt<=N, busy<=1,
//   div_by_zero<=0, ->RUN. Outputs quotient/remainder keep old values while busy.
//  IDLE, start=1 at edge k, divisor==0: stay IDLE; quotient<={N{1}}, remainder<=dividend[D-1:0],
//   div_by_zero<=1, done<=1 (pulse visible after edge k, latency 1).
//  RUN, each edge: t={r_acc[D-1:0],q_sh[N-1]}; if t>=dvs: r_acc<=t-dvs, q_sh<={q_sh[N-2:0],1}
//   else r_acc<=t, q_sh<={q_sh[N-2:0],0}; cnt<=cnt-1.
//  RUN, edge where cnt==1 (k+N): final iteration result written to quotient/remainder, done<=1, busy<=0, ->IDLE.
//  Latency: start edge k -> done high in cycle after edge k+N (N=8: 8 clocks). Throughput: 1 op per N clocks,
//   back-to-back allowed: start may be asserted in the done cycle and is accepted at that edge.
//  done: exactly one cycle high per accepted start; cleared on next edge unless a new zero-divisor op completes.
//  start while busy=1: ignored, no effect on operands, state or outputs.
//  Width: t is D+1 bits so compare never overflows; remainder always < divisor; quotient*divisor+remainder=dividend.
//  Reset mid-RUN: async abort, all outputs to reset values, no done pulse; next start runs normally.
//  No X propagation: unused register bits cleared on reset; outputs fully registered.
// TESTING
//  1 dividend=143, divisor=11, start 1 cycle -> done 8 clocks later, quotient=13, remainder=0, div_by_zero=0.
//  2 dividend=200, divisor=7 -> quotient=28, remainder=4; then 255/1 -> 255 r0; 0/15 -> 0 r0; 255/15 -> 17 r0.
//  3 dividend=8'h5A, divisor=0 -> done next cycle, quotient=8'hFF, remainder=4'hA, div_by_zero=1, busy never 1.
//  4 start pulsed at cycles 2 and 5 of a run (busy=1) -> ignored, single done, result of first operands;
//    start held high through done cycle -> second op accepted, second done exactly N clocks after first.
//  5 rst_n low after 4 iterations -> busy=0, done=0, quotient=0, remainder=0 immediately; no done afterwards.
//  6 exhaustive: for all a in 0..15, b in 1..15: dividend=a*b, divisor=b -> quotient=a, remainder=0;
//    plus random dividend/divisor!=0 checked against q*d+r==dividend, r<d.

Source files
------------

// File: rtl/seq_div8x4.sv
// seq_div8x4: sequential restoring divider, N-bit dividend by D-bit divisor, one quotient bit per clock
module seq_div8x4 #(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [D-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [D-1:0] remainder_o,
  output logic         div_by_zero_o
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   q_sh_q, q_sh_d, quot_q, quot_d;
  logic [D-1:0]   r_acc_q, r_acc_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [D:0]     t;
  logic [D-1:0]   r_nxt;
  logic [N-1:0]   q_nxt;
  logic           ge, accept, zero, last;
  // partial remainder stays below the divisor, so the extra compare bit lives only in t
  assign t      = {r_acc_q, q_sh_q[N-1]};
  assign ge     = t >= {1'b0, dvs_q};
  assign r_nxt  = ge ? D'(t - {1'b0, dvs_q}) : t[D-1:0];
  assign q_nxt  = {q_sh_q[N-2:0], ge};
  assign accept = state_q == IDLE && start_i;
  assign zero   = divisor_i == '0;
  assign last   = state_q == RUN && cnt_q == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = accept && !zero ? RUN : last ? IDLE : state_q;
  always_comb begin
    q_sh_d  = state_q == RUN ? q_nxt : accept && !zero ? dividend_i : q_sh_q;
    r_acc_d = state_q == RUN ? r_nxt : accept && !zero ? '0 : r_acc_q;
    dvs_d   = accept && !zero ? divisor_i : dvs_q;
    cnt_d   = state_q == RUN ? cnt_q - CW'(1) : accept && !zero ? CW'(N) : cnt_q;
    quot_d  = last ? q_nxt : accept && zero ? '1 : quot_q;
    rem_d   = last ? r_nxt : accept && zero ? dividend_i[D-1:0] : rem_q;
    dbz_d   = accept ? zero : dbz_q;
    done_d  = last || (accept && zero);
    busy_d  = state_d == RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_sh_q  <= '0;
      r_acc_q <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      q_sh_q  <= q_sh_d;
      r_acc_q <= r_acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;
endmodule
